// File: rtl/sqroot_arbiter_pkg.sv
// Shared definitions for the square-root arbiter slice.
//   state_e      : arbiter FSM states (IDLE, CALC, HOLD)
//   NREQ_DEF     : default number of requesters
//   NBITS_DEF    : default operand width
//   res_width()  : result width for a given operand width (NBITS/2+1)
package sqroot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 8;

  // One extra bit over NBITS/2 so round-to-nearest can reach 2^(NBITS/2).
  function automatic int res_width(input int nbits);
    return nbits / 2 + 1;
  endfunction

endpackage

// File: rtl/sqroot_comb.sv
// Combinational integer square root.
//   arg     : operand, NBITS wide
//   roundup : 0 = floor(sqrt(arg)), 1 = sqrt(arg) rounded to nearest
//   sqroot  : result, NBITS/2+1 wide
module sqroot_comb
  import sqroot_arbiter_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic [NBITS-1:0]            arg,
  input  logic                        roundup,
  output logic [res_width(NBITS)-1:0] sqroot
);

  localparam int HB = NBITS / 2;
  localparam int RW = res_width(NBITS);

  logic [HB-1:0]    root_s;
  logic [NBITS-1:0] rem_s;
  logic             up_s;

  // Bit-serial floor root: try each result bit from the MSB down, keep it
  // when the candidate squared still fits under the operand.
  always_comb begin
    logic [HB-1:0]    cand_v;
    logic [NBITS-1:0] sq_v;
    root_s = '0;
    cand_v = '0;
    sq_v   = '0;
    for (int i = HB - 1; i >= 0; i--) begin
      cand_v = root_s | (HB'(1'b1) << i);
      sq_v   = {{(NBITS-HB){1'b0}}, cand_v} * {{(NBITS-HB){1'b0}}, cand_v};
      if (sq_v <= arg) begin
        root_s = cand_v;
      end else begin
        root_s = root_s;
      end
    end
  end

  // sqrt(arg) >= r+0.5 exactly when arg - r^2 > r (the remainder is an
  // integer, so an exact tie can never occur).
  always_comb begin
    rem_s = arg - ({{(NBITS-HB){1'b0}}, root_s} * {{(NBITS-HB){1'b0}}, root_s});
    up_s  = roundup && (rem_s > {{(NBITS-HB){1'b0}}, root_s});
    sqroot = {1'b0, root_s} + {{(RW-1){1'b0}}, up_s};
  end

endmodule

// File: rtl/sqroot_arbiter.sv
// Round-robin arbiter sharing one square-root datapath among NREQ requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester request strobe
//   req_arg     : packed operands, requester i at [i*NBITS +: NBITS]
//   req_roundup : per-requester rounding mode
//   req_ready   : one-hot grant, combinational in IDLE
//   rsp_valid   : result available (HOLD)
//   rsp_id      : index of the requester owning the result
//   rsp_sqroot  : square-root result
//   rsp_ready   : consumer accepts the result
//   busy        : high outside IDLE
module sqroot_arbiter
  import sqroot_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*NBITS-1:0]       req_arg,
  input  logic [NREQ-1:0]             req_roundup,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [res_width(NBITS)-1:0] rsp_sqroot,
  input  logic                        rsp_ready,
  output logic                        busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = res_width(NBITS);

  state_e           state_r;
  state_e           next_state_s;
  logic [IDW-1:0]   ptr_r;
  logic [NBITS-1:0] arg_r;
  logic             roundup_r;
  logic [RW-1:0]    dp_root_s;
  logic             found_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             accept_s;
  logic [NBITS-1:0] arg_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign arg_a[g] = req_arg[g*NBITS +: NBITS];
  end

  // Round-robin search starting at ptr_r; NREQ is a power of two so the
  // index addition wraps naturally.
  always_comb begin
    logic [IDW-1:0] idx_v;
    logic           hit_v;
    found_s     = 1'b0;
    grant_idx_s = '0;
    idx_v       = '0;
    hit_v       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v       = ptr_r + IDW'(k);
      hit_v       = !found_s && req_valid[idx_v];
      grant_idx_s = hit_v ? idx_v : grant_idx_s;
      found_s     = found_s | hit_v;
    end
  end

  // FSM next state and grant; req_ready is forced low while reset is held.
  always_comb begin
    next_state_s = state_r;
    req_ready    = '0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && rst_n) begin
          req_ready    = NREQ'(1'b1) << grant_idx_s;
          accept_s     = 1'b1;
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        next_state_s = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      rsp_valid <= (next_state_s == HOLD);
      busy      <= (next_state_s != IDLE);
    end
  end

  // Grant-time capture: operands, owner id and the next search start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= '0;
      arg_r     <= '0;
      roundup_r <= 1'b0;
      rsp_id    <= '0;
    end else if (accept_s) begin
      ptr_r     <= grant_idx_s + IDW'(1'b1);
      arg_r     <= arg_a[grant_idx_s];
      roundup_r <= req_roundup[grant_idx_s];
      rsp_id    <= grant_idx_s;
    end else begin
      ptr_r     <= ptr_r;
      arg_r     <= arg_r;
      roundup_r <= roundup_r;
      rsp_id    <= rsp_id;
    end
  end

  // Result register, loaded only during the single CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sqroot <= '0;
    end else if (state_r == CALC) begin
      rsp_sqroot <= dp_root_s;
    end else begin
      rsp_sqroot <= rsp_sqroot;
    end
  end

  // The datapath sees only the latched operands.
  sqroot_comb #(
    .NBITS (NBITS)
  ) u_sqroot_comb (
    .arg     (arg_r),
    .roundup (roundup_r),
    .sqroot  (dp_root_s)
  );

endmodule

// File: tb/tb_sqroot_arbiter.sv
// Directed self-checking bench for sqroot_arbiter (NREQ=4, NBITS=8).
module tb_sqroot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_arg;
  logic [3:0]  req_roundup;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_sqroot;
  logic        rsp_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  sqroot_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_arg     (req_arg),
    .req_roundup (req_roundup),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_sqroot  (rsp_sqroot),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor by counting up; rounding by comparing 4*a with (2r+1)^2.
  function automatic int ref_sqrt(input int a, input bit ru);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    if (ru && (4 * a >= (2 * r + 1) * (2 * r + 1))) r++;
    return r;
  endfunction

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One full transaction for a single requester, starting in IDLE.
  task automatic txn(input int id, input logic [7:0] a, input logic ru, input int exp, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    req_valid = onehot;
    req_arg[id*8 +: 8] = a;
    req_roundup[id] = ru;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, req_ready, onehot);
    step();
    req_valid = 4'b0000;
    chk({tag, "_calc_valid"}, rsp_valid, 1'b0);
    chk({tag, "_calc_busy"}, busy, 1'b1);
    step();
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, id[1:0]);
    chk({tag, "_root"}, rsp_sqroot, exp);
    step();
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 4'b1111;
    req_arg     = 32'h0;
    req_roundup = 4'b0000;
    rsp_ready   = 1'b0;
    step();
    step();
    // Reset state, with requests pending
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_sqroot", rsp_sqroot, 5'd0);
    rst_n = 1'b1;
    req_valid = 4'b0000;

    // Single request, granted on the first edge after reset release
    txn(0, 8'd144, 1'b0, 12, "single144");
    // Rounding corners
    txn(0, 8'd255, 1'b1, 16, "r255_up");
    txn(1, 8'd255, 1'b0, 15, "r255_dn");
    txn(2, 8'd0,   1'b0, 0,  "r0_dn");
    txn(3, 8'd0,   1'b1, 0,  "r0_up");
    txn(0, 8'd2,   1'b1, 1,  "r2_up");
    txn(1, 8'd8,   1'b1, 3,  "r8_up");
    txn(1, 8'd6,   1'b1, 2,  "r6_up");

    // Backpressure: requester 2 served, requester 0 waits through HOLD (ptr=2)
    req_valid = 4'b0100;
    req_arg[16 +: 8] = 8'd100;
    req_roundup[2] = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant2", req_ready, 4'b0100);
    step();
    req_valid = 4'b0001;
    req_arg[0 +: 8] = 8'd49;
    req_roundup[0] = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_id", rsp_id, 2'd2);
      chk("bp_hold_root", rsp_sqroot, 5'd10);
      chk("bp_hold_ready", req_ready, 4'b0000);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_no_grant", req_ready, 4'b0000);
    step();
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_valid", rsp_valid, 1'b0);
    chk("bp_idle_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    step();
    chk("bp_next_id", rsp_id, 2'd0);
    chk("bp_next_root", rsp_sqroot, 5'd7);
    step();

    // Reset in CALC aborts the operation
    req_valid = 4'b0010;
    req_arg[8 +: 8] = 8'd81;
    #1;
    chk("rm_grant1", req_ready, 4'b0010);
    step();
    req_valid = 4'b1110;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", rsp_valid, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_id", rsp_id, 2'd0);
    chk("rm_root", rsp_sqroot, 5'd0);
    chk("rm_ready", req_ready, 4'b0000);
    step();
    chk("rm_no_rsp", rsp_valid, 1'b0);

    // Round-robin with all four requesters held high; ptr restarts at 0
    req_arg = {8'd64, 8'd36, 8'd25, 8'd16};
    req_roundup = 4'b0000;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_oh;
      int exp_root;
      exp_oh = 4'b0001 << (k % 4);
      exp_root = ref_sqrt(int'(req_arg[(k % 4)*8 +: 8]), 1'b0);
      #1;
      chk("rr_grant", req_ready, exp_oh);
      step();
      chk("rr_calc_ready", req_ready, 4'b0000);
      step();
      chk("rr_hold_ready", req_ready, 4'b0000);
      chk("rr_id", rsp_id, k % 4);
      chk("rr_root", rsp_sqroot, exp_root);
      step();
    end
    req_valid = 4'b0000;
    step();
    step();
    step();

    // Exhaustive sweep through requester 3
    for (int a = 0; a < 256; a++) begin
      for (int m = 0; m < 2; m++) begin
        txn(3, a[7:0], m[0], ref_sqrt(a, m[0]), "sweep");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
